dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the single-cycle RV32I core: the target end of the core's `dm_addr`/`dm_wdata`/`dm_web`/`dm_rdata` data-memory interface. Provides a byte-writable word RAM with combinational read and a small MMIO window. The window holds a 64-bit cycle counter, a halt/tohost register and a 4-entry byte output FIFO with a valid/ready drain port. Sits beside the CPU in the top-level and testbench, replacing a bare SRAM model.

## Interface
- `DEPTH_WORDS`, 16384: RAM size in 32-bit words (64 KiB); power of two.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `MMIO_BASE`, 32'hFFFF_0000: base of MMIO window (64-byte region).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dm_addr`  in  32  byte address from CPU.
- `dm_wdata`  in  32  store data, already lane-aligned by CPU.
- `dm_web`  in  4  per-byte write enable, bit i=1 writes byte lane i (bits [8i+7:8i]); 4'b0000 = no write.
- `dm_rdata`  out  32  aligned word at `dm_addr & ~3`, combinational.
- `out_data`  out  8  FIFO head byte.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head this cycle.
- `halt`  out  1  sticky; set by TOHOST write.
- `halt_code`  out  32  last value written to TOHOST.

## Operation
- Decode on `dm_addr`: RAM if `dm_addr < DEPTH_WORDS*4`; MMIO if `dm_addr[31:6] == MMIO_BASE[31:6]`; else unmapped.
- RAM index = `dm_addr[log2(DEPTH_WORDS)+1:2]`. Low 2 address bits ignored. The CPU performs load-lane extraction and sign extension.
- Writes: each enabled lane of addressed word updated at posedge. RAM contents not reset.
- Unmapped: read 0, writes ignored.
- Reads have no side effects. `dm_addr` is driven every cycle by the ALU, so no register may change on a read.
- MMIO map (offset from base):
  - 0x00 CYCLE_LO (RO): counter[31:0].
  - 0x04 CYCLE_HI (RO): counter[63:32]. No snapshot between halves.
  - 0x08 TOHOST (RW): on write with any `dm_web` bit, enabled lanes are merged into `halt_code` and `halt` is set to 1. Reads return `halt_code`.
  - 0x0C OUT_DATA (WO, read 0): write with `dm_web[0]=1` pushes `dm_wdata[7:0]`.
  - 0x10 OUT_STATUS: reads `{21'b0, overflow[10], full[9], empty[8], count[7:0]}`. A write with `dm_web[1]=1` and `dm_wdata[10]=1` clears `overflow`. Other bits are read-only.
  - Other offsets: read 0, write ignored.
- Cycle counter: 64-bit, increments every cycle while `halt==0`, and freezes while `halt==1`. Wraps from 2^64−1 to 0.
- FIFO: circular buffer with read/write pointers and count.
  - Pop when `out_valid && out_ready`.
  - Push on OUT_DATA write.
  - Push when full without a simultaneous pop: byte dropped, `overflow` set (sticky).
  - Push when full with a simultaneous pop: push accepted, count unchanged.
  - Simultaneous push and pop when not full: count unchanged, both accepted.
  - Push on empty with `out_ready=1`: no same-cycle bypass; byte appears on the next cycle.
- `out_data` = entry at read pointer, and is stable while `out_valid && !out_ready`.
- Reset values: `dm_rdata` follows decode (counter region reads 0); `out_valid=0`; `out_data=0`; `halt=0`; `halt_code=0`; counter=0; pointers, count and overflow=0.

## Timing
- Read latency 0: `dm_rdata` is combinational from `dm_addr` and current state.
- Write commits at posedge. A same-cycle read of the written address returns the old value; the next cycle returns the new value.
- `halt` and `halt_code` update 1 cycle after the TOHOST write cycle.
- FIFO push visible on `out_valid`/`count` the next cycle. A pop advances the head at the posedge of the handshake cycle.
- Counter equals the number of rising edges since reset deassertion, excluding halted cycles.
- Reset asserted mid-operation immediately clears all non-RAM state (asynchronous). FIFO contents are discarded and RAM is preserved.

## Test plan
- Byte merge: write 0xAABBCCDD to 0x100 with web=1111, then wdata=0x00001100 with web=0010 → read 0x100 returns 0xAABB11DD. A same-cycle read during the second write returns 0xAABBCCDD.
- Counter: release reset, read CYCLE_LO after 10 posedges → 10. Preload the counter via force to 0xFFFFFFFF_FFFFFFFF → next cycle CYCLE_HI=0, CYCLE_LO=0.
- FIFO fill/drain: with out_ready=0, push 0x41, 0x42, 0x43, 0x44, 0x45 → OUT_STATUS=0x0000_0604 (full, overflow, count 4). Set out_ready=1 → out_data 0x41..0x44 on 4 consecutive cycles, then out_valid=0 and OUT_STATUS=0x0000_0500. Clear-write of overflow → 0x0000_0100.
- Full push+pop: FIFO full, out_ready=1, push 0x55 in the same cycle → count stays 4, overflow stays 0, and 0x55 emerges fifth.
- Halt: write 0x00000001 to TOHOST → next cycle halt=1, halt_code=1, CYCLE_LO constant over the following 5 cycles, TOHOST reads 1.
- Unmapped/reset: write 0xDEAD to 0x8000_0000 → read returns 0. Assert rst with 3 bytes queued → out_valid=0, count=0, halt=0, and RAM word 0x100 is unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory target for the RV32I core: byte-writable word RAM plus an
// MMIO window with cycle counter, tohost/halt register and byte output FIFO.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_web,
  output logic [31:0] dm_rdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [3:0] OFF_CYC_LO = 4'h0;
  localparam logic [3:0] OFF_CYC_HI = 4'h1;
  localparam logic [3:0] OFF_TOHOST = 4'h2;
  localparam logic [3:0] OFF_OUT    = 4'h3;
  localparam logic [3:0] OFF_STATUS = 4'h4;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] ram_idx;
  logic          ram_sel;
  logic          mmio_sel;
  logic [3:0]    off;
  logic          wr_any;
  logic          unused_addr_lsb;

  assign ram_idx  = dm_addr[AW+1:2];
  assign ram_sel  = (dm_addr[31:AW+2] == '0);
  assign mmio_sel = (dm_addr[31:6] == MMIO_BASE[31:6]);
  assign off      = dm_addr[5:2];
  assign wr_any   = |dm_web;
  assign unused_addr_lsb = ^dm_addr[1:0];

  // RAM is deliberately left out of reset so a reset preserves memory
  always_ff @(posedge clk) begin
    if (ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (dm_web[i]) begin
          mem[ram_idx][8*i +: 8] <= dm_wdata[8*i +: 8];
        end
      end
    end
  end

  logic        tohost_we;
  logic        push_req;
  logic        ovf_clr;
  logic [31:0] code_next;

  assign tohost_we = mmio_sel && (off == OFF_TOHOST) && wr_any;
  assign push_req  = mmio_sel && (off == OFF_OUT) && dm_web[0];
  assign ovf_clr   = mmio_sel && (off == OFF_STATUS)
                     && dm_web[1] && dm_wdata[10];

  always_comb begin
    code_next = halt_code;
    for (int i = 0; i < 4; i++) begin
      if (dm_web[i]) begin
        code_next[8*i +: 8] = dm_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt      <= 1'b0;
      halt_code <= '0;
    end else if (tohost_we) begin
      halt      <= 1'b1;
      halt_code <= code_next;
    end
  end

  logic [63:0] cycle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle <= '0;
    end else if (!halt) begin
      cycle <= cycle + 64'd1;
    end
  end

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          empty;
  logic          full;
  logic          pop;
  logic          accept;

  assign empty  = (count == '0);
  assign full   = (count == CW'(FIFO_DEPTH));
  assign pop    = !empty && out_ready;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign accept = push_req && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_mem[i] <= '0;
      end
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        fifo_mem[wr_ptr] <= dm_wdata[7:0];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(accept) - CW'(pop);
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign out_valid = !empty;
  assign out_data  = fifo_mem[rd_ptr];

  logic [7:0]  count_byte;
  logic [31:0] status;
  logic [31:0] mmio_rdata;

  assign count_byte = 8'(count);
  assign status = {21'b0, overflow, full, empty, count_byte};

  always_comb begin
    mmio_rdata = '0;
    case (off)
      OFF_CYC_LO: mmio_rdata = cycle[31:0];
      OFF_CYC_HI: mmio_rdata = cycle[63:32];
      OFF_TOHOST: mmio_rdata = halt_code;
      OFF_STATUS: mmio_rdata = status;
      default:    mmio_rdata = '0;
    endcase
  end

  always_comb begin
    dm_rdata = '0;
    unique case (1'b1)
      ram_sel:  dm_rdata = mem[ram_idx];
      mmio_sel: dm_rdata = mmio_rdata;
      default:  dm_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table for RAM/decode plus
// hand sequences for counter, FIFO, halt and reset corner cases.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_web;
  logic [31:0] dm_rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        halt;
  logic [31:0] halt_code;

  dmem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_web    (dm_web),
    .dm_rdata  (dm_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halt      (halt),
    .halt_code (halt_code)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A_LO  = 32'hFFFF_0000;
  localparam logic [31:0] A_HI  = 32'hFFFF_0004;
  localparam logic [31:0] A_TH  = 32'hFFFF_0008;
  localparam logic [31:0] A_OUT = 32'hFFFF_000C;
  localparam logic [31:0] A_ST  = 32'hFFFF_0010;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  web;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tab [18];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr,
                        input logic [31:0] exp);
    dm_addr = addr;
    dm_web  = 4'h0;
    #1;
    check(name, dm_rdata, exp);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    dm_addr  = A_OUT;
    dm_wdata = {24'h0, b};
    dm_web   = 4'h1;
  endtask

  initial begin
    tab[0]  = '{32'h0000_0100, 32'hAABB_CCDD, 4'hF, 1'b0, 32'h0};
    tab[1]  = '{32'h0000_0100, 32'h0000_1100, 4'h2, 1'b1, 32'hAABB_CCDD};
    tab[2]  = '{32'h0000_0100, 32'h0,         4'h0, 1'b1, 32'hAABB_11DD};
    tab[3]  = '{32'h0000_0103, 32'h0,         4'h0, 1'b1, 32'hAABB_11DD};
    tab[4]  = '{32'h0000_0104, 32'h1122_3344, 4'hF, 1'b0, 32'h0};
    tab[5]  = '{32'h0000_0104, 32'h0000_00EE, 4'h1, 1'b1, 32'h1122_3344};
    tab[6]  = '{32'h0000_0104, 32'h0,         4'h0, 1'b1, 32'h1122_33EE};
    tab[7]  = '{32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'h0};
    tab[8]  = '{32'h0000_FFFC, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
    tab[9]  = '{32'h0001_0000, 32'hCAFE_BABE, 4'hF, 1'b1, 32'h0};
    tab[10] = '{32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'h0};
    tab[11] = '{32'h0000_FFFC, 32'h0,         4'h0, 1'b1, 32'h1234_5678};
    tab[12] = '{32'h8000_0000, 32'h0000_DEAD, 4'hF, 1'b1, 32'h0};
    tab[13] = '{32'h8000_0000, 32'h0,         4'h0, 1'b1, 32'h0};
    tab[14] = '{32'hFFFF_0014, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    tab[15] = '{A_OUT,         32'h0,         4'h0, 1'b1, 32'h0};
    tab[16] = '{A_ST,          32'h0,         4'h0, 1'b1, 32'h0000_0100};
    tab[17] = '{32'hFFFE_FFC0, 32'h0,         4'h0, 1'b1, 32'h0};

    rst = 1'b1;
    dm_addr = '0;
    dm_wdata = '0;
    dm_web = '0;
    out_ready = 1'b0;

    @(negedge clk);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_data", {24'h0, out_data}, 32'h0);
    check("rst_halt", {31'h0, halt}, 32'h0);
    check("rst_code", halt_code, 32'h0);
    rd_chk("rst_status", A_ST, 32'h0000_0100);
    rd_chk("rst_cyc_lo", A_LO, 32'h0);
    rd_chk("rst_cyc_hi", A_HI, 32'h0);
    rst = 1'b0;

    repeat (10) @(posedge clk);
    @(negedge clk);
    rd_chk("cyc_10", A_LO, 32'd10);

    force dut.cycle = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cycle;
    rd_chk("cyc_pre_hi", A_HI, 32'hFFFF_FFFF);
    @(negedge clk);
    rd_chk("cyc_wrap_hi", A_HI, 32'h0);
    rd_chk("cyc_wrap_lo", A_LO, 32'h0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      dm_addr  = tab[i].addr;
      dm_wdata = tab[i].wdata;
      dm_web   = tab[i].web;
      #1;
      if (tab[i].chk) begin
        check($sformatf("vec%0d", i), dm_rdata, tab[i].exp);
      end
    end

    for (int i = 0; i < 5; i++) push(8'h41 + 8'(i));
    @(negedge clk);
    rd_chk("fill_status", A_ST, 32'h0000_0604);
    check("fill_head", {24'h0, out_data}, 32'h41);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), {24'h0, out_data}, 32'h41 + i);
      check($sformatf("drain_v%0d", i), {31'h0, out_valid}, 32'h1);
      @(negedge clk);
      #1;
    end
    check("drained_v", {31'h0, out_valid}, 32'h0);
    rd_chk("drained_st", A_ST, 32'h0000_0500);
    out_ready = 1'b0;
    dm_wdata = 32'h0000_0400;
    dm_web   = 4'h2;
    @(negedge clk);
    rd_chk("ovf_clr", A_ST, 32'h0000_0100);

    for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
    push(8'h55);
    out_ready = 1'b1;
    #1;
    check("fp_head", {24'h0, out_data}, 32'h61);
    @(negedge clk);
    rd_chk("fp_status", A_ST, 32'h0000_0204);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fp_out%0d", i), {24'h0, out_data},
            (i == 3) ? 32'h55 : 32'h62 + i);
      @(negedge clk);
      #1;
    end
    check("fp_empty", {31'h0, out_valid}, 32'h0);
    rd_chk("fp_st_end", A_ST, 32'h0000_0100);
    out_ready = 1'b0;

    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    @(negedge clk);
    dm_addr  = A_TH;
    dm_wdata = 32'h0000_0001;
    dm_web   = 4'hF;
    #1;
    check("th_halt_pre", {31'h0, halt}, 32'h0);
    check("th_old_read", dm_rdata, 32'h0);
    @(negedge clk);
    dm_web = 4'h0;
    #1;
    check("th_halt", {31'h0, halt}, 32'h1);
    check("th_code", halt_code, 32'h1);
    check("th_read", dm_rdata, 32'h1);
    for (int i = 0; i < 5; i++) begin
      rd_chk($sformatf("frozen%0d", i), A_LO, 32'd2);
      @(negedge clk);
    end
    dm_addr  = A_TH;
    dm_wdata = 32'h0000_AB00;
    dm_web   = 4'h2;
    @(negedge clk);
    dm_web = 4'h0;
    #1;
    check("th_merge", halt_code, 32'h0000_AB01);

    for (int i = 0; i < 3; i++) push(8'h71 + 8'(i));
    @(negedge clk);
    dm_web = 4'h0;
    #1;
    check("q3_valid", {31'h0, out_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check("ar_valid", {31'h0, out_valid}, 32'h0);
    check("ar_data", {24'h0, out_data}, 32'h0);
    check("ar_halt", {31'h0, halt}, 32'h0);
    check("ar_code", halt_code, 32'h0);
    rd_chk("ar_status", A_ST, 32'h0000_0100);
    rd_chk("ar_cyc", A_LO, 32'h0);
    rd_chk("ar_ram", 32'h0000_0100, 32'hAABB_11DD);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_chk("post_status", A_ST, 32'h0000_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
